word_serializer: RTL and testbench

- Downstream stage of the encoder datapath: takes a parallel word plus a bit-count and shifts it out one bit per clock.
- Feeds narrow serial sinks such as the UART/SPI style test harnesses and single-bit links.
- Accepts a new word only when idle and reports occupancy through busy_o.

---
 rtl/word_serializer_pkg.sv | 16 +
 rtl/word_serializer.sv | 78 +++++++
 tb/tb_word_serializer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/word_serializer_pkg.sv
// Shared types and helpers for the word serializer.
package word_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Requests shorter than this are dropped.
  localparam int unsigned MIN_LEN = 3;

  function automatic int unsigned eff_len(input int unsigned mod, input int unsigned width);
    return (mod == 0) ? width : mod;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial word shifter with bit-count, one bit per clock.
// Optional build macro WORD_SERIALIZER_LSB_FIRST_EN: emit LSB first and count valid bits from the LSB.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned MOD_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [MOD_W-1:0] data_mod_i,
  input  logic             data_val_i,
  output logic             ser_data_o,
  output logic             ser_data_val_o,
  output logic             busy_o
);

  // One extra bit so the counter can hold WIDTH itself.
  localparam int unsigned CNT_W = MOD_W + 1;

`ifdef WORD_SERIALIZER_LSB_FIRST_EN
  localparam int unsigned OUT_IDX = 0;
`else
  localparam int unsigned OUT_IDX = WIDTH - 1;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  int unsigned      len;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    len     = eff_len(32'(data_mod_i), WIDTH);
    case (state_q)
      IDLE: begin
        if (data_val_i && (len >= MIN_LEN)) begin
          sh_d    = data_i;
          cnt_d   = CNT_W'(len);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
`ifdef WORD_SERIALIZER_LSB_FIRST_EN
        sh_d = {1'b0, sh_q[WIDTH-1:1]};
`else
        sh_d = {sh_q[WIDTH-2:0], 1'b0};
`endif
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; the output bit is gated low while idle.
  assign busy_o         = (state_q == SHIFT);
  assign ser_data_val_o = busy_o;
  assign ser_data_o     = busy_o & sh_q[OUT_IDX];

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: directed scenarios plus random traffic against a queue model.
module tb_word_serializer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned MOD_W = 4;

  logic             clk = 1'b0;
  logic             srst = 1'b1;
  logic [WIDTH-1:0] data = '0;
  logic [MOD_W-1:0] mod = '0;
  logic             val = 1'b0;
  logic             ser, ser_val, busy;

  int unsigned total  = 0;
  int unsigned passed = 0;

  bit exp_q[$];
  logic [WIDTH-1:0] collected;

  word_serializer #(.WIDTH(WIDTH)) dut (
    .clk_i         (clk),
    .srst_i        (srst),
    .data_i        (data),
    .data_mod_i    (mod),
    .data_val_i    (val),
    .ser_data_o    (ser),
    .ser_data_val_o(ser_val),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
  endtask

  // One clock: the model pops the bit just shown, or accepts a word if it was idle.
  task automatic step(input string tag);
    logic             s_rst, s_val;
    logic [WIDTH-1:0] s_data;
    int unsigned      l;
    s_rst  = srst;
    s_val  = val;
    s_data = data;
    l      = (mod == 0) ? WIDTH : int'(mod);
    @(posedge clk);
    if (s_rst) begin
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end else if (s_val && l >= 3) begin
      for (int unsigned i = 0; i < l; i++) begin
`ifdef WORD_SERIALIZER_LSB_FIRST_EN
        exp_q.push_back(s_data[i]);
`else
        exp_q.push_back(s_data[WIDTH-1-i]);
`endif
      end
    end
    #1;
    chk({tag, ".val"},  ser_val, exp_q.size() != 0);
    chk({tag, ".busy"}, busy,    exp_q.size() != 0);
    chk({tag, ".data"}, ser,     (exp_q.size() != 0) ? exp_q[0] : 1'b0);
    if (ser_val) collected = {collected[WIDTH-2:0], ser};
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic [MOD_W-1:0] m, input int unsigned cycles, input string tag);
    data = d;
    mod  = m;
    val  = 1'b1;
    step(tag);
    val  = 1'b0;
    for (int unsigned i = 1; i < cycles; i++) step(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] word_exp;
    logic [WIDTH-1:0] lit;
    int unsigned      vcount;

    repeat (3) step("reset");
    srst = 1'b0;
    step("post_reset");

    // Reset mid-word on the 5th output cycle.
    send(16'hFFFF, 4'd0, 5, "rst_mid");
    srst = 1'b1;
    step("rst_mid_assert");
    srst = 1'b0;
    repeat (4) step("rst_mid_after");

    // Full word; also reassemble the serial stream and count valid cycles.
    collected = '0;
    vcount    = 0;
    data = 16'hA5C3; mod = 4'd0; val = 1'b1;
    step("full");
    val = 1'b0;
    for (int unsigned i = 0; i < 18; i++) begin
      if (ser_val) vcount++;
      step("full");
    end
    lit = 16'hA5C3;
`ifdef WORD_SERIALIZER_LSB_FIRST_EN
    for (int unsigned i = 0; i < WIDTH; i++) word_exp[i] = lit[WIDTH-1-i];
`else
    word_exp = lit;
`endif
    total++;
    assert (collected === word_exp) passed++;
    else $error("FAIL full_word: observed %h expected %h", collected, word_exp);
    total++;
    assert (vcount == 16) passed++;
    else $error("FAIL full_count: observed %0d expected 16", vcount);

    send(16'hF000, 4'd5, 8, "partial");
    send(16'hFFFF, 4'd1, 3, "drop1");
    send(16'hFFFF, 4'd2, 3, "drop2");
    send(16'h6000, 4'd3, 6, "min3");
    send(16'h0001, 4'd4, 7, "lsb_word");

    // Continuous request; a different word slipped in while busy must not appear.
    data = 16'hFFFF; mod = 4'd4; val = 1'b1;
    repeat (3) step("b2b");
    data = 16'h0000; mod = 4'd0;
    step("b2b_other");
    data = 16'hFFFF; mod = 4'd4;
    repeat (12) step("b2b");
    val = 1'b0;
    repeat (6) step("b2b_tail");

    for (int unsigned i = 0; i < 400; i++) begin
      data = WIDTH'($urandom);
      mod  = MOD_W'($urandom_range(0, 15));
      val  = ($urandom_range(0, 3) != 0);
      srst = ($urandom_range(0, 59) == 0);
      step("random");
    end
    srst = 1'b0;
    val  = 1'b0;
    repeat (20) step("drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
